// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: request type codes,
// exception codes, FSM state encoding and the alignment check.
package dm_access_unit_pkg;

    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_BU = 3'b001;
    localparam logic [2:0] T_H  = 3'b010;
    localparam logic [2:0] T_HU = 3'b011;
    localparam logic [2:0] T_W  = 3'b100;
    localparam logic [2:0] T_WU = 3'b101;
    localparam logic [2:0] T_D  = 3'b110;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Returns 1 when the access cannot be performed: misaligned for its size,
    // or a type the datapath width does not support (wu/d on 32-bit, 111 always).
    function automatic logic is_misaligned(input logic [2:0] req_type,
                                           input logic [2:0] addr_lo,
                                           input logic       wide);
        logic bad;
        bad = 1'b1;
        case (req_type)
            T_B, T_BU: bad = 1'b0;
            T_H, T_HU: bad = addr_lo[0];
            T_W:       bad = |addr_lo[1:0];
            T_WU:      bad = (|addr_lo[1:0]) || !wide;
            T_D:       bad = (|addr_lo) || !wide;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_access_unit_load_ext.sv
// Load extender: selects the addressed lane of a full memory word and
// sign- or zero-extends it to the datapath width.
module dm_load_ext
    import dm_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             rdata,
    input  logic [$clog2(DATA_W/8)-1:0]   lane,
    input  logic [2:0]                    req_type,
    output logic [DATA_W-1:0]             ext_data
);

    logic [DATA_W-1:0] shifted;

    // Right-justify the addressed lane, then extend according to the type.
    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (req_type)
            T_B:     ext_data = DATA_W'($signed(shifted[7:0]));
            T_BU:    ext_data = DATA_W'(shifted[7:0]);
            T_H:     ext_data = DATA_W'($signed(shifted[15:0]));
            T_HU:    ext_data = DATA_W'(shifted[15:0]);
            T_W:     ext_data = DATA_W'($signed(shifted[31:0]));
            T_WU:    ext_data = DATA_W'(shifted[31:0]);
            default: ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Multi-cycle MEM-stage load/store controller: one request per handshake,
// alignment check, aligned memory port drive, fixed-latency read capture and
// held response with AdEL/AdES reporting.
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_type,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_exc,
    output logic [4:0]            rsp_exc_code
);

    localparam int   BE_W  = DATA_W / 8;
    localparam int   OFF_W = $clog2(BE_W);
    localparam logic WIDE  = (DATA_W == 64);

    state_t            state, state_next;
    logic [2:0]        cnt;
    logic              we_q;
    logic [2:0]        type_q;
    logic [OFF_W-1:0]  lane_q;
    logic              bad;
    logic              capture;
    logic [BE_W-1:0]   be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] ext_data;

    assign bad     = is_misaligned(req_type, req_addr[2:0], WIDE);
    assign capture = (state == S_WAIT) && (cnt == 3'(MEM_LAT));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = bad ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                mem_en     = !reset;
                mem_we     = we_q && !reset;
                state_next = we_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (capture) state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Store lane placement: byte-enable run at the lane offset, data replicated per lane.
    always_comb begin
        be_next    = '0;
        wdata_next = '0;
        case (req_type[2:1])
            2'b00: begin
                be_next    = BE_W'(1) << req_addr[OFF_W-1:0];
                wdata_next = {(DATA_W/8){req_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = BE_W'(2'b11) << req_addr[OFF_W-1:0];
                wdata_next = {(DATA_W/16){req_wdata[15:0]}};
            end
            2'b10: begin
                be_next    = BE_W'(4'hF) << req_addr[OFF_W-1:0];
                wdata_next = {(DATA_W/32){req_wdata[31:0]}};
            end
            default: begin
                be_next    = '1;
                wdata_next = req_wdata;
            end
        endcase
    end

    // Request latch, memory port registers, latency counter and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            we_q         <= 1'b0;
            type_q       <= '0;
            lane_q       <= '0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            rsp_rdata    <= '0;
            rsp_exc      <= 1'b0;
            rsp_exc_code <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q         <= req_we;
                        type_q       <= req_type;
                        lane_q       <= req_addr[OFF_W-1:0];
                        cnt          <= '0;
                        rsp_rdata    <= '0;
                        rsp_exc      <= bad;
                        rsp_exc_code <= bad ? (req_we ? EXC_ADES : EXC_ADEL) : 5'd0;
                        if (!bad) begin
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_be    <= req_we ? be_next : '1;
                            mem_wdata <= req_we ? wdata_next : '0;
                        end
                    end
                end
                S_ISSUE: cnt <= 3'd1;
                S_WAIT: begin
                    if (capture) rsp_rdata <= ext_data;
                    else         cnt       <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    dm_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .rdata    (mem_rdata),
        .lane     (lane_q),
        .req_type (type_q),
        .ext_data (ext_data)
    );

endmodule
